// File: rtl/lse_simd_pkg.sv
// Shared constants, mode encoding and CLUT generator for the LSE SIMD unit.
package lse_simd_pkg;

    typedef enum logic {
        LSE_MODE = 1'b0,
        MAX_MODE = 1'b1
    } mode_e;

    function automatic logic [63:0] neg_inf(input int w);
        return 64'(1) << (w - 1);
    endfunction

    function automatic logic [63:0] pos_sat(input int w);
        return (64'(1) << (w - 1)) - 64'(1);
    endfunction

    // round(2^frac * log2(1 + 2^(-i/2))), evaluated at elaboration only
    function automatic int clut_entry(input int i, input int frac);
        real v;
        v = (2.0 ** frac) * $ln(1.0 + 2.0 ** (-i / 2.0)) / $ln(2.0);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/lse_simd_lanes_clut.sv
// Combinational correction ROM: half-unit distance index -> log2 correction.
module lse_clut_rom
    import lse_simd_pkg::*;
#(
    parameter int LUT_SIZE  = 16,
    parameter int FRAC_BITS = 10,
    parameter int IDX_W     = $clog2(LUT_SIZE)
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [FRAC_BITS:0] corr
);

    logic [FRAC_BITS:0] tab [LUT_SIZE];

    for (genvar g = 0; g < LUT_SIZE; g++) begin : g_tab
        localparam int E = clut_entry(g, FRAC_BITS);
        assign tab[g] = E[FRAC_BITS:0];
    end

    assign corr = tab[idx];

endmodule

// File: rtl/lse_simd_lanes.sv
// Multi-lane log-sum-exp unit: three-stage pipeline with global stall,
// per-lane saturation and a shared saturating overflow counter.
module lse_simd_lanes #(
    parameter int LANES     = 2,
    parameter int LANE_W    = 24,
    parameter int FRAC_BITS = 10,
    parameter int LUT_SIZE  = 16,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*LANE_W-1:0] x_in,
    input  logic [LANES*LANE_W-1:0] y_in,
    input  logic                    mode_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [LANES*LANE_W-1:0] result,
    output logic [LANES-1:0]        overflow,
    output logic                    valid_out,
    input  logic                    ready_out,
    input  logic                    ovf_clr,
    output logic [CNT_W-1:0]        ovf_count
);
    import lse_simd_pkg::*;

    localparam int IDX_W = $clog2(LUT_SIZE);
    localparam logic [LANE_W-1:0] NEG = LANE_W'(neg_inf(LANE_W));
    localparam logic [LANE_W-1:0] POS = LANE_W'(pos_sat(LANE_W));

    logic                    advance;
    logic                    v1, v2, v3;
    logic [LANES*LANE_W-1:0] x1, y1;
    mode_e                   m1;

    assign advance   = !v3 || ready_out;
    assign ready_in  = advance;
    assign valid_out = v3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            x1 <= '0;
            y1 <= '0;
            m1 <= LSE_MODE;
        end else if (advance) begin
            v1 <= valid_in;
            v2 <= v1;
            v3 <= v2;
            x1 <= x_in;
            y1 <= y_in;
            m1 <= mode_e'(mode_in);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0]  a, b, lmax, lmin, corr_c;
        logic [LANE_W:0]    d, idx_full, sum;
        logic [FRAC_BITS:0] rom_corr;
        logic [LANE_W-1:0]  l2, c2, res3;
        logic               both2, ovf3;

        assign a    = x1[i*LANE_W +: LANE_W];
        assign b    = y1[i*LANE_W +: LANE_W];
        assign lmax = ($signed(a) >= $signed(b)) ? a : b;
        assign lmin = ($signed(a) >= $signed(b)) ? b : a;
        assign d    = {lmax[LANE_W-1], lmax} - {lmin[LANE_W-1], lmin};
        assign idx_full = d >> (FRAC_BITS - 1);

        lse_clut_rom #(
            .LUT_SIZE  (LUT_SIZE),
            .FRAC_BITS (FRAC_BITS)
        ) u_rom (
            .idx  (idx_full[IDX_W-1:0]),
            .corr (rom_corr)
        );

        // A NEG_INF operand contributes nothing, so the other value passes
        always_comb begin
            corr_c = '0;
            if (m1 == LSE_MODE && lmin != NEG &&
                idx_full < (LANE_W+1)'(LUT_SIZE))
                corr_c = LANE_W'(rom_corr);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                l2    <= '0;
                c2    <= '0;
                both2 <= 1'b0;
            end else if (advance) begin
                l2    <= lmax;
                c2    <= corr_c;
                both2 <= (a == NEG) && (b == NEG);
            end
        end

        assign sum = {l2[LANE_W-1], l2} + {1'b0, c2};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                res3 <= '0;
                ovf3 <= 1'b0;
            end else if (advance) begin
                if (both2) begin
                    res3 <= NEG;
                    ovf3 <= 1'b0;
                end else if ($signed(sum) > $signed({1'b0, POS})) begin
                    res3 <= POS;
                    ovf3 <= 1'b1;
                end else begin
                    res3 <= sum[LANE_W-1:0];
                    ovf3 <= 1'b0;
                end
            end
        end

        assign result[i*LANE_W +: LANE_W] = res3;
        assign overflow[i] = ovf3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_count <= '0;
        else if (ovf_clr)
            ovf_count <= '0;
        else if (v3 && ready_out && |overflow && ovf_count != '1)
            ovf_count <= ovf_count + 1'b1;
    end

endmodule
